// File: rtl/ring_tap_sweeper.sv
// Tapped ring oscillator sweep sequencer: settles, gates and counts divided oscillator edges per tap.
// Optional RING_SWEEP_LOOP_EN: restart from tap_first after the last tap while `loop` is high.
module ring_tap_sweeper #(
  parameter int CNT_W  = 16,
  parameter int GATE_W = 12,
  parameter int SETTLE = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic              loop,
  input  logic [2:0]        tap_first,
  input  logic [2:0]        tap_last,
  input  logic [GATE_W-1:0] gate_len,
  input  logic              osc_div,
  output logic              ring_ena,
  output logic [2:0]        tap,
  output logic              busy,
  output logic              result_valid,
  output logic [2:0]        result_tap,
  output logic [CNT_W-1:0]  result_count,
  output logic              result_ovf,
  output logic              done
);

  localparam int SET_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_MEASURE, S_REPORT} state_t;

  state_t              state_q, state_d;
  logic                sync1_q, sync1_d, sync2_q, sync2_d, prev_q, prev_d;
  logic [SET_W-1:0]    settle_q, settle_d;
  logic [GATE_W-1:0]   gate_q, gate_d;
  logic [GATE_W-1:0]   glen_q, glen_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d, cnt_nx;
  logic                ovf_q, ovf_d, ovf_nx;
  logic [2:0]          first_q, first_d, last_q, last_d;
  logic                ring_ena_q, ring_ena_d, busy_q, busy_d;
  logic [2:0]          tap_q, tap_d;
  logic                rv_q, rv_d, done_q, done_d;
  logic [2:0]          rtap_q, rtap_d;
  logic [CNT_W-1:0]    rcnt_q, rcnt_d;
  logic                rovf_q, rovf_d;
  logic                edge_pulse;

`ifndef RING_SWEEP_LOOP_EN
  logic loop_unused;
  assign loop_unused = loop;
`endif

  always_comb begin
    state_d  = state_q;
    sync1_d  = osc_div;
    sync2_d  = sync1_q;
    prev_d   = sync2_q;
    settle_d = settle_q;
    gate_d   = gate_q;
    glen_d   = glen_q;
    cnt_d    = cnt_q;
    ovf_d    = ovf_q;
    first_d  = first_q;
    last_d   = last_q;
    tap_d    = tap_q;
    rv_d     = 1'b0;
    done_d   = 1'b0;
    rtap_d   = rtap_q;
    rcnt_d   = rcnt_q;
    rovf_d   = rovf_q;

    edge_pulse = sync2_q & ~prev_q;
    cnt_nx     = cnt_q;
    ovf_nx     = ovf_q;
    if (state_q == S_MEASURE && edge_pulse) begin
      if (&cnt_q) ovf_nx = 1'b1;
      else        cnt_nx = cnt_q + 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (start && !abort) begin
          first_d  = tap_first;
          last_d   = tap_last;
          glen_d   = gate_len;
          tap_d    = tap_first;
          settle_d = SET_W'(SETTLE - 1);
          state_d  = S_SETTLE;
        end
      end
      S_SETTLE: begin
        if (settle_q == '0) begin
          state_d = S_MEASURE;
          cnt_d   = '0;
          ovf_d   = 1'b0;
          // gate_len of 0 wraps to all-ones, giving the full 2^GATE_W window
          gate_d  = glen_q - 1'b1;
        end else begin
          settle_d = settle_q - 1'b1;
        end
      end
      S_MEASURE: begin
        cnt_d = cnt_nx;
        ovf_d = ovf_nx;
        if (gate_q == '0) begin
          state_d = S_REPORT;
          rv_d    = 1'b1;
          done_d  = (tap_q == last_q);
          rtap_d  = tap_q;
          rcnt_d  = cnt_nx;
          rovf_d  = ovf_nx;
        end else begin
          gate_d = gate_q - 1'b1;
        end
      end
      default: begin
        settle_d = SET_W'(SETTLE - 1);
        if (tap_q == last_q) begin
`ifdef RING_SWEEP_LOOP_EN
          if (loop) begin
            state_d = S_SETTLE;
            tap_d   = first_q;
            glen_d  = gate_len;
          end else begin
            state_d = S_IDLE;
          end
`else
          state_d = S_IDLE;
`endif
        end else begin
          tap_d   = tap_q + 3'd1;
          state_d = S_SETTLE;
        end
      end
    endcase

    // Abort overrides everything, including a result that would load this edge
    if (abort && state_q != S_IDLE) begin
      state_d = S_IDLE;
      rv_d    = 1'b0;
      done_d  = 1'b0;
      rtap_d  = rtap_q;
      rcnt_d  = rcnt_q;
      rovf_d  = rovf_q;
    end

    ring_ena_d = (state_d != S_IDLE);
    busy_d     = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      sync1_q    <= 1'b0;
      sync2_q    <= 1'b0;
      prev_q     <= 1'b0;
      settle_q   <= '0;
      gate_q     <= '0;
      glen_q     <= '0;
      cnt_q      <= '0;
      ovf_q      <= 1'b0;
      first_q    <= '0;
      last_q     <= '0;
      tap_q      <= '0;
      ring_ena_q <= 1'b0;
      busy_q     <= 1'b0;
      rv_q       <= 1'b0;
      done_q     <= 1'b0;
      rtap_q     <= '0;
      rcnt_q     <= '0;
      rovf_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      prev_q     <= prev_d;
      settle_q   <= settle_d;
      gate_q     <= gate_d;
      glen_q     <= glen_d;
      cnt_q      <= cnt_d;
      ovf_q      <= ovf_d;
      first_q    <= first_d;
      last_q     <= last_d;
      tap_q      <= tap_d;
      ring_ena_q <= ring_ena_d;
      busy_q     <= busy_d;
      rv_q       <= rv_d;
      done_q     <= done_d;
      rtap_q     <= rtap_d;
      rcnt_q     <= rcnt_d;
      rovf_q     <= rovf_d;
    end
  end

  assign ring_ena     = ring_ena_q;
  assign tap          = tap_q;
  assign busy         = busy_q;
  assign result_valid = rv_q;
  assign result_tap   = rtap_q;
  assign result_count = rcnt_q;
  assign result_ovf   = rovf_q;
  assign done         = done_q;

endmodule

// File: tb/tb_ring_tap_sweeper.sv
// Scoreboard bench for ring_tap_sweeper: expected results queued at start, checked by a monitor.
// Counts are predicted from the bench's own log of osc_div rising edges.
module tb_ring_tap_sweeper;
  localparam int CNT_W  = 5;
  localparam int GATE_W = 8;
  localparam int SETTLE = 16;
  localparam int unsigned CMAX = (1 << CNT_W) - 1;

  logic              clk = 1'b0;
  logic              rst, start, abort, loop;
  logic [2:0]        tap_first, tap_last;
  logic [GATE_W-1:0] gate_len;
  logic              osc_div;
  logic              ring_ena, busy, result_valid, result_ovf, done;
  logic [2:0]        tap, result_tap;
  logic [CNT_W-1:0]  result_count;

  ring_tap_sweeper #(.CNT_W(CNT_W), .GATE_W(GATE_W), .SETTLE(SETTLE)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .loop(loop),
    .tap_first(tap_first), .tap_last(tap_last), .gate_len(gate_len),
    .osc_div(osc_div), .ring_ena(ring_ena), .tap(tap), .busy(busy),
    .result_valid(result_valid), .result_tap(result_tap),
    .result_count(result_count), .result_ovf(result_ovf), .done(done)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [2:0]  tap;
    bit          done;
    int unsigned cyc;
    int unsigned g;
  } exp_t;
  exp_t sbq[$];

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input bit ok, input int unsigned act, input int unsigned exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Divided oscillator: square wave with period osc_per clk cycles, rising edges logged by cycle
  bit edge_at [0:65535];
  int unsigned osc_per = 4;
  initial begin
    int unsigned ph;
    bit nv;
    ph = 1;
    osc_div = 1'b0;
    forever begin
      @(negedge clk);
      ph = (ph + 1) % osc_per;
      nv = (ph < osc_per / 2);
      if (nv && !osc_div) edge_at[cyc] = 1'b1;
      osc_div = nv;
    end
  end

  // Monitor: a pulse counted at edge j came from a rise logged 3 cycles earlier,
  // so the G-cycle window ending at report cycle R covers rises [R-G-2, R-3].
  initial begin
    exp_t e;
    int unsigned n, lo, hi;
    forever begin
      @(negedge clk);
      if (result_valid) begin
        if (sbq.size() == 0) begin
          check("unexpected_result", 1'b0, result_tap, 0);
        end else begin
          e = sbq.pop_front();
          check("res_tap", result_tap == e.tap, result_tap, e.tap);
          check("res_done", done == e.done, done, e.done);
          check("res_cycle", cyc == e.cyc, cyc, e.cyc);
          n = 0;
          for (int unsigned k = cyc - e.g - 2; k <= cyc - 3; k++) n += edge_at[k];
          lo = (n > 0) ? n - 1 : 0;
          hi = n + 1;
          lo = (lo > CMAX) ? CMAX : lo;
          hi = (hi > CMAX) ? CMAX : hi;
          check("res_count", result_count >= lo && result_count <= hi, result_count, n);
          if (n + 1 <= CMAX) check("res_ovf", result_ovf == 1'b0, result_ovf, 0);
          else if (n > CMAX + 1) check("res_ovf", result_ovf == 1'b1, result_ovf, 1);
        end
      end else if (done) begin
        check("done_without_valid", 1'b0, 1, 0);
      end
    end
  end

  initial begin
    repeat (60000) @(posedge clk);
    $display("FAIL watchdog: got cycle %0d, expected completion earlier", cyc);
    $fatal(1, "watchdog expired");
  end

  task automatic check_reset_vals();
    check("rst_ring_ena", ring_ena == 1'b0, ring_ena, 0);
    check("rst_tap", tap == 3'd0, tap, 0);
    check("rst_busy", busy == 1'b0, busy, 0);
    check("rst_result_valid", result_valid == 1'b0, result_valid, 0);
    check("rst_done", done == 1'b0, done, 0);
    check("rst_result_tap", result_tap == 3'd0, result_tap, 0);
    check("rst_result_count", result_count == '0, result_count, 0);
    check("rst_result_ovf", result_ovf == 1'b0, result_ovf, 0);
  endtask

  task automatic issue(input logic [2:0] f, input logic [2:0] l, input logic [GATE_W-1:0] g,
                       input int unsigned keep, input bit scramble, output int unsigned n);
    int unsigned gg, ntap;
    exp_t e;
    @(negedge clk);
    tap_first = f; tap_last = l; gate_len = g; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = cyc;
    check("start_ena", ring_ena == 1'b1 && busy == 1'b1, {ring_ena, busy}, 3);
    check("start_tap", tap == f, tap, f);
    if (scramble) begin
      tap_first = 3'($urandom); tap_last = 3'($urandom); gate_len = GATE_W'($urandom);
    end
    gg = (g == 0) ? (1 << GATE_W) : int'(g);
    ntap = int'(3'(l - f)) + 1;
    for (int unsigned k = 0; k < keep; k++) begin
      e.tap  = 3'(f + 3'(k % ntap));
      e.done = ((k % ntap) == ntap - 1);
      e.cyc  = n + SETTLE + gg + k * (SETTLE + gg + 1);
      e.g    = gg;
      sbq.push_back(e);
    end
  endtask

  task automatic drain(input bit loop_mode);
    int unsigned t, drops;
    t = 0; drops = 0;
    while (sbq.size() != 0 && t < 5000) begin
      @(negedge clk); #1;
      if (loop_mode && !ring_ena) drops++;
      t++;
    end
    check("drain", sbq.size() == 0, sbq.size(), 0);
    if (loop_mode) check("loop_ena_held", drops == 0, drops, 0);
    @(negedge clk); #1;
    check("end_idle", !ring_ena && !busy, {ring_ena, busy}, 0);
  endtask

  initial begin
    int unsigned n, t;
    rst = 1'b1; start = 1'b0; abort = 1'b0; loop = 1'b0;
    tap_first = '0; tap_last = '0; gate_len = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check_reset_vals();

    osc_per = 4;
    issue(3'd3, 3'd3, 8'd100, 1, 1'b1, n);
    drain(1'b0);

    osc_per = $urandom_range(3, 8);
    issue(3'd6, 3'd1, 8'd20, 4, 1'b1, n);
    drain(1'b0);

    osc_per = 3;
    issue(3'd5, 3'd5, 8'd200, 1, 1'b1, n);
    drain(1'b0);

    osc_per = 5;
    issue(3'd0, 3'd0, 8'd0, 1, 1'b1, n);
    drain(1'b0);

    // Abort in the middle of the second tap's window
    osc_per = 4;
    issue(3'd1, 3'd4, 8'd40, 1, 1'b1, n);
    t = 0;
    while (cyc < n + (SETTLE + 40 + 1) + SETTLE + 20 && t < 1000) begin @(negedge clk); t++; end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_ena", ring_ena == 1'b0 && busy == 1'b0, {ring_ena, busy}, 0);
    repeat (150) @(negedge clk);
    check("abort_flush", sbq.size() == 0, sbq.size(), 0);

    // start and abort together in IDLE
    start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    check("start_abort_idle", busy == 1'b0 && ring_ena == 1'b0, {ring_ena, busy}, 0);
    repeat (5) @(negedge clk);
    check("start_abort_stay", busy == 1'b0, busy, 0);

    // Reset during SETTLE
    issue(3'd2, 3'd5, 8'd30, 0, 1'b1, n);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_reset_vals();
    rst = 1'b0;
    issue(3'd7, 3'd0, 8'd12, 2, 1'b1, n);
    drain(1'b0);

    for (int i = 0; i < 6; i++) begin
      logic [2:0] f, l;
      logic [GATE_W-1:0] g;
      osc_per = $urandom_range(3, 8);
      f = 3'($urandom);
      l = 3'($urandom);
      g = ($urandom_range(0, 9) == 0) ? '0 : GATE_W'($urandom_range(4, 120));
`ifdef RING_SWEEP_LOOP_EN
      loop = 1'b0;
`else
      loop = 1'($urandom);
`endif
      issue(f, l, g, int'(3'(l - f)) + 1, 1'b1, n);
      drain(1'b0);
    end

`ifdef RING_SWEEP_LOOP_EN
    osc_per = 4;
    loop = 1'b1;
    issue(3'd2, 3'd3, 8'd30, 6, 1'b0, n);
    t = 0;
    while (sbq.size() > 1 && t < 3000) begin @(negedge clk); #1; t++; end
    loop = 1'b0;
    drain(1'b1);
`else
    loop = 1'b1;
    issue(3'd2, 3'd3, 8'd30, 2, 1'b1, n);
    drain(1'b0);
    loop = 1'b0;
`endif

    repeat (10) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ring_tap_sweeper.md
# ring_tap_sweeper

Sequencer for the tapped ring oscillator. Steps the ring's 3-bit tap select through a programmed range. At each tap it enables the ring, waits a settle interval, then counts rising edges of a divided oscillator output over a gate window of `clk` cycles and reports one result per tap. It sits between the top-level input pins and the ring/divider, and drives the ring's `ena` and `tap` in place of direct pin control.

## Interface
- `CNT_W`, 16: width of edge counter / result_count
- `GATE_W`, 12: width of gate_len and gate timer
- `SETTLE`, 16: settle cycles per tap (≥1)
- `clk` in 1: sole clock
- `rst` in 1: reset, synchronous, active-high
- `start` in 1: begin sweep (sampled in IDLE only)
- `abort` in 1: stop sweep immediately
- `loop` in 1: restart sweep after last tap (only with RING_SWEEP_LOOP_EN)
- `tap_first` in 3: first tap of sweep
- `tap_last` in 3: last tap of sweep (inclusive)
- `gate_len` in GATE_W: measurement window in clk cycles; 0 means 2^GATE_W
- `osc_div` in 1: divided oscillator output, asynchronous to clk
- `ring_ena` out 1: ring enable
- `tap` out 3: ring tap select
- `busy` out 1: high whenever state ≠ IDLE
- `result_valid` out 1: one-cycle pulse, result fields valid
- `result_tap` out 3: tap measured
- `result_count` out CNT_W: edges counted in window
- `result_ovf` out 1: counter saturated
- `done` out 1: one-cycle pulse with final result of a sweep

## Operation
- States: IDLE, SETTLE, MEASURE, REPORT.
- IDLE: `ring_ena`=0, `busy`=0. On `start`=1, latch `tap_first`, `tap_last`, `gate_len` → SETTLE; `tap`=`tap_first`.
- SETTLE: `ring_ena`=1; runs SETTLE cycles, then → MEASURE with edge counter cleared.
- MEASURE: runs G cycles (G = latched gate_len, or 2^GATE_W if 0). Counts each synchronized rising edge of `osc_div`. Counter saturates at all-ones and sets the ovf flag. Edges during SETTLE are never counted.
- REPORT: one cycle. `result_valid`=1. `result_tap`/`result_count`/`result_ovf` are loaded and held until the next REPORT.
  - If `tap` == latched `tap_last`: `done`=1, then → IDLE with `ring_ena`=0.
  - Otherwise `tap` ← `tap`+1 mod 8, then → SETTLE.
- Wrap-around: the sweep increments modulo 8. `tap_first`=6, `tap_last`=1 gives taps 6,7,0,1. `tap_first`==`tap_last` gives a single tap.
- Synchronizer: `osc_div` → 2 flops → edge detect (sync2 & ~prev). This is valid for `osc_div` ≤ clk/3; faster inputs undercount, and that is not flagged.
- `abort`=1 in any non-IDLE state → IDLE next cycle. `ring_ena`=0; no result_valid, no done. `abort` takes priority over REPORT transitions. `abort` in IDLE is ignored; `abort` and `start` together in IDLE → stays IDLE.
- `start` outside IDLE is ignored. Input changes after latching have no effect until the next sweep.

## Timing
- Reset values: state IDLE; `ring_ena` 0, `tap` 0, `busy` 0, `result_valid` 0, `done` 0, `result_tap` 0, `result_count` 0, `result_ovf` 0. Synchronizer flops 0.
- `rst` mid-sweep: next edge returns all outputs to reset values; no partial result.
- `start` sampled at edge N → SETTLE, `ring_ena`=1, `busy`=1 from N+1.
- Per tap: SETTLE + G + 1 cycles. First `result_valid` at cycle N+1+SETTLE+G.
- Edge latency: edge counted 2–3 cycles after the `osc_div` transition. Edges arriving in the final 2 cycles of MEASURE fall into the next window or are dropped (±1 count tolerance).
- All outputs registered.

## Configuration
- `RING_SWEEP_LOOP_EN` defined: in REPORT of the last tap with `loop`=1, emit `done` and go to SETTLE with `tap`=latched `tap_first`, re-latching `gate_len`. `ring_ena` stays 1. `loop`=0 behaves as without the macro.
- Not defined: `loop` is ignored and the sweep always ends in IDLE.

## Test plan
- SETTLE=16, tap_first=tap_last=3, gate_len=100, osc_div = clk/4 square wave, start pulse → single result_valid at cycle 117 after start; result_tap=3, count 25±1, ovf=0, done together with it, then ring_ena=0.
- tap_first=6, tap_last=1, gate_len=20 → four results in order taps 6,7,0,1, spaced 37 cycles apart; done only on tap 1.
- CNT_W=4, gate_len=100, osc_div=clk/4 → count=15, result_ovf=1.
- abort asserted mid-MEASURE of the second tap → IDLE next cycle, ring_ena=0, no further result_valid or done. start in same cycle as abort in IDLE → no sweep.
- rst pulsed during SETTLE → all outputs at reset values next cycle. A subsequent start runs normally. gate_len=0 with GATE_W=4 → 16-cycle window.
- RING_SWEEP_LOOP_EN, loop=1, taps 2..3 → results 2,3,2,3,…; done after each tap 3; ring_ena never drops. Deassert loop → ends in IDLE after next tap 3.
